// File: rtl/redun_mont_pkg.sv
// Shared constants and types for the redundant Montgomery datapath and its output normalizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package redun_mont_pkg;

  // Canonical digit width and number of redundant words in a result.
  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 4;

  // Default stream geometry of the output normalizer.
  localparam int NORM_T_LEN   = 64;
  localparam int NORM_AXI_LEN = 32;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int NORM_IN_BITS   = NORM_T_LEN + 16 + NUM_WRDS * (WRD_BITS + 1);
  localparam int NORM_IN_COUNT  = ceil_div(NORM_IN_BITS, NORM_AXI_LEN);
  localparam int NORM_OUT_BITS  = NORM_T_LEN + 16 + NUM_WRDS * WRD_BITS + 2;
  localparam int NORM_OUT_COUNT = ceil_div(NORM_OUT_BITS, NORM_AXI_LEN);

  typedef enum logic [1:0] {
    RECV = 2'd0,
    NORM = 2'd1,
    SEND = 2'd2
  } norm_state_t;

endpackage

// File: rtl/redun_carry_step.sv
// Registered single-word carry stage: d/carry_out <= split(w + carry_in) when enable is high.
// Latency: 1 cycle from enable to updated d/carry_out.
// Backpressure: none; the caller decides when to pulse enable, outputs hold otherwise.
//
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   w [WRD_BITS:0]     one redundant word (digit plus one extra bit)
//   carry_in [1:0]     incoming carry, 0..2
//   enable             load the result of this step
//   d [WRD_BITS-1:0]   canonical digit of the last enabled step
//   carry_out [1:0]    carry produced by the last enabled step
module redun_carry_step #(
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WRD_BITS:0]   w,
  input  logic [1:0]          carry_in,
  input  logic                enable,
  output logic [WRD_BITS-1:0] d,
  output logic [1:0]          carry_out
);

  logic [WRD_BITS+1:0] w_sum;
  logic [WRD_BITS-1:0] r_d;
  logic [1:0]          r_carry;

  // w < 2^(W+1) and carry <= 2, so the sum is below 2^(W+1)+2 and the
  // upper two bits never exceed 2.
  assign w_sum = (WRD_BITS+2)'(w) + (WRD_BITS+2)'(carry_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d     <= '0;
      r_carry <= '0;
    end else if (enable) begin
      r_d     <= w_sum[WRD_BITS-1:0];
      r_carry <= w_sum[WRD_BITS+1:WRD_BITS];
    end
  end

  assign d         = r_d;
  assign carry_out = r_carry;

endmodule

// File: rtl/redun_out_normalizer.sv
// Captures one redundant-form result frame, carry-propagates it word-serially, re-emits it packed.
// Latency: first output word NUM_WRDS+1 cycles after the input tlast is accepted.
// Backpressure: s_axis_tready only in RECV; output words hold stable while m_axis_tready is low.
//
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   s_axis_t{valid,ready,data,last}  input stream, LSW first
//   m_axis_t{valid,ready,data,keep,last}  output stream, LSW first, keep all-ones
//   frame_err                     sticky: an input frame had the wrong length
//   frames_done                   count of fully sent output frames (wraps)
module redun_out_normalizer
  import redun_mont_pkg::*;
#(
  parameter int AXI_LEN  = 32,
  parameter int T_LEN    = 64,
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS = redun_mont_pkg::NUM_WRDS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [AXI_LEN-1:0]   s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [AXI_LEN-1:0]   m_axis_tdata,
  output logic [AXI_LEN/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 frame_err,
  output logic [31:0]          frames_done
);

  localparam int HDR_BITS  = T_LEN + 16;
  localparam int IN_BITS   = HDR_BITS + NUM_WRDS * (WRD_BITS + 1);
  localparam int IN_COUNT  = ceil_div(IN_BITS, AXI_LEN);
  localparam int IN_REG    = IN_COUNT * AXI_LEN;
  localparam int OUT_BITS  = HDR_BITS + NUM_WRDS * WRD_BITS + 2;
  localparam int OUT_COUNT = ceil_div(OUT_BITS, AXI_LEN);
  localparam int OUT_REG   = OUT_COUNT * AXI_LEN;
  localparam int CNT_W     = $clog2(IN_COUNT + 2);
  localparam int IDX_W     = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam int OIDX_W    = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

  norm_state_t r_state, w_state_nxt;

  logic [IN_REG-1:0]                  r_in, w_in_nxt;
  logic [CNT_W-1:0]                   r_cnt, w_cnt_inc;
  logic [IDX_W-1:0]                   r_idx;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]  r_dig;
  logic [OUT_REG-1:0]                 r_out, w_out_load;
  logic [OIDX_W-1:0]                  r_widx;
  logic                               r_frame_err;
  logic [31:0]                        r_frames_done;

  logic                w_s_acc;
  logic                w_len_ok;
  logic                w_norm_last;
  logic                w_send_last;
  logic [WRD_BITS:0]   w_step_w;
  logic [1:0]          w_step_cin;
  logic                w_step_en;
  logic [WRD_BITS-1:0] w_step_d;
  logic [1:0]          w_step_cout;

  // Stream outputs decode registered state only; reset_n gates tready so
  // the input looks not-ready for the whole time reset is held.
  assign s_axis_tready = (r_state == RECV) && reset_n;
  assign m_axis_tvalid = (r_state == SEND);
  assign m_axis_tlast  = (r_state == SEND) && w_send_last;
  assign m_axis_tdata  = r_out[AXI_LEN-1:0];
  assign m_axis_tkeep  = '1;
  assign frame_err     = r_frame_err;
  assign frames_done   = r_frames_done;

  assign w_s_acc     = s_axis_tvalid && s_axis_tready;
  assign w_in_nxt    = {s_axis_tdata, r_in[IN_REG-1:AXI_LEN]};
  assign w_cnt_inc   = (r_cnt == CNT_W'(IN_COUNT + 1)) ? r_cnt : r_cnt + 1'b1;
  assign w_len_ok    = (w_cnt_inc == CNT_W'(IN_COUNT));
  assign w_norm_last = (r_idx == IDX_W'(NUM_WRDS - 1));
  assign w_send_last = (r_widx == OIDX_W'(OUT_COUNT - 1));

  // The carry stage runs one word ahead of the NORM index: word 0 is fed
  // from the not-yet-registered input shift value on the tlast edge, so by
  // the last NORM cycle the stage already holds the final digit and carry
  // and the output register can be loaded on that same edge.
  always_comb begin
    w_step_w   = w_in_nxt[HDR_BITS +: WRD_BITS+1];
    w_step_cin = '0;
    w_step_en  = 1'b0;
    if (r_state == RECV) begin
      w_step_en = w_s_acc && s_axis_tlast && w_len_ok;
    end else if ((r_state == NORM) && !w_norm_last) begin
      w_step_w   = r_in[HDR_BITS + (int'(r_idx) + 1) * (WRD_BITS + 1) +: WRD_BITS+1];
      w_step_cin = w_step_cout;
      w_step_en  = 1'b1;
    end
  end

  redun_carry_step #(
    .WRD_BITS (WRD_BITS)
  ) u_carry_step (
    .clk       (clk),
    .reset_n   (reset_n),
    .w         (w_step_w),
    .carry_in  (w_step_cin),
    .enable    (w_step_en),
    .d         (w_step_d),
    .carry_out (w_step_cout)
  );

  // Packed output frame: header, digits 0..N-2 from r_dig, the last digit
  // and final carry straight from the carry stage, zero padding above.
  always_comb begin
    w_out_load = '0;
    w_out_load[HDR_BITS-1:0] = r_in[HDR_BITS-1:0];
    for (int i = 0; i < NUM_WRDS - 1; i++) begin
      w_out_load[HDR_BITS + i*WRD_BITS +: WRD_BITS] = r_dig[i];
    end
    w_out_load[HDR_BITS + (NUM_WRDS-1)*WRD_BITS +: WRD_BITS] = w_step_d;
    w_out_load[HDR_BITS + NUM_WRDS*WRD_BITS +: 2]            = w_step_cout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RECV;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RECV: begin
        if (s_axis_tvalid && s_axis_tlast && w_len_ok) begin
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (w_norm_last) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready && w_send_last) begin
          w_state_nxt = RECV;
        end
      end
      default: w_state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in          <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_dig         <= '0;
      r_out         <= '0;
      r_widx        <= '0;
      r_frame_err   <= 1'b0;
      r_frames_done <= '0;
    end else begin
      unique case (r_state)
        RECV: begin
          r_idx <= '0;
          if (w_s_acc) begin
            r_in <= w_in_nxt;
            if (s_axis_tlast) begin
              // Counter restarts for the next frame whether or not this one was kept.
              r_cnt <= '0;
              if (!w_len_ok) begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        NORM: begin
          r_dig[r_idx] <= w_step_d;
          r_idx        <= r_idx + 1'b1;
          if (w_norm_last) begin
            r_out  <= w_out_load;
            r_widx <= '0;
            r_idx  <= '0;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            // Zero-fill from the top so the register is empty once drained.
            r_out  <= r_out >> AXI_LEN;
            r_widx <= r_widx + 1'b1;
            if (w_send_last) begin
              r_widx        <= '0;
              r_frames_done <= r_frames_done + 32'd1;
            end
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redun_out_normalizer.sv
module tb_redun_out_normalizer;
  import redun_mont_pkg::*;

  localparam int AXI_LEN   = 32;
  localparam int T_LEN     = 64;
  localparam int OUT_COUNT = 5;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [AXI_LEN-1:0]   s_axis_tdata = '0;
  logic                 s_axis_tlast = 1'b0;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [AXI_LEN-1:0]   m_axis_tdata;
  logic [AXI_LEN/8-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 frame_err;
  logic [31:0]          frames_done;

  always #5 clk = ~clk;

  redun_out_normalizer #(
    .AXI_LEN  (AXI_LEN),
    .T_LEN    (T_LEN),
    .WRD_BITS (16),
    .NUM_WRDS (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .frame_err     (frame_err),
    .frames_done   (frames_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] frame_w[0:7];
  int          tx_cnt = 0;
  int          fdone_exp = 0;
  logic        bp_mode = 1'b0;

  // Reference model: pack the input frame, carry-propagate, queue the packed output words.
  task automatic build(input logic [63:0] t, input logic [15:0] seed,
                       input logic [3:0][16:0] w, input bit push);
    logic [159:0] inb;
    logic [159:0] outb;
    logic [17:0]  s;
    logic [1:0]   c;
    inb  = '0;
    outb = '0;
    c    = 2'd0;
    inb[63:0]  = t;
    inb[79:64] = seed;
    for (int i = 0; i < 4; i++) inb[80 + i*17 +: 17] = w[i];
    for (int j = 0; j < 5; j++) frame_w[j] = inb[j*32 +: 32];
    outb[63:0]  = t;
    outb[79:64] = seed;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, w[i]} + {16'd0, c};
      outb[80 + i*16 +: 16] = s[15:0];
      c = s[17:16];
    end
    outb[144 +: 2] = c;
    if (push) begin
      for (int j = 0; j < OUT_COUNT; j++)
        exp_q.push_back(beat_t'{dat: outb[j*32 +: 32], last: (j == OUT_COUNT-1)});
    end
  endtask

  task automatic build_rand(input bit push);
    logic [3:0][16:0] w;
    for (int i = 0; i < 4; i++) w[i] = 17'($urandom);
    build({$urandom, $urandom}, 16'($urandom), w, push);
  endtask

  task automatic send_frame(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame_w[i];
      s_axis_tlast  = (i == n-1);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (s_axis_tready) begin
          ok = 1'b1;
          break;
        end
      end
      check("send_tmo", ok, 1'b1);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_tmo", ok, 1'b1);
    fdone_exp++;
    check("frames_done", frames_done, 64'(fdone_exp));
  endtask

  // Downstream ready: constant 1, or toggling every cycle in backpressure mode.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on transfer, stability while stalled.
  logic [31:0] prev_dat;
  logic        prev_last;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else if (m_axis_tvalid) begin
      check("tready_in_send", s_axis_tready, 1'b0);
      check("tkeep", m_axis_tkeep, 4'hF);
      if (prev_stall) begin
        check("hold_dat", m_axis_tdata, prev_dat);
        check("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tready) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", m_axis_tvalid, 1'b0);
        end else begin
          b = exp_q.pop_front();
          check("out_dat", m_axis_tdata, b.dat);
          check("out_last", m_axis_tlast, b.last);
        end
      end
      prev_stall = !m_axis_tready;
      prev_dat   = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int  tx0;
    int  lat;
    bit  ok;

    // Reset state.
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_frames_done", frames_done, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_tready", s_axis_tready, 1'b1);

    // All-max words: carries saturate at 2.
    build(64'd5, 16'hABCD, {4{17'h1FFFF}}, 1'b1);
    send_frame(5);
    wait_done();

    // Already canonical, plus first-output latency.
    build(64'h0123_4567_89AB_CDEF, 16'h1234,
          {17'h0DEF0, 17'h09ABC, 17'h05678, 17'h01234}, 1'b1);
    send_frame(5);
    lat = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      lat++;
      if (m_axis_tvalid) break;
    end
    check("latency", lat, 5);
    wait_done();

    // Backpressure: ready toggling every cycle.
    bp_mode = 1'b1;
    build_rand(1'b1);
    tx0 = tx_cnt;
    send_frame(5);
    wait_done();
    check("bp_xfers", tx_cnt - tx0, 5);
    bp_mode = 1'b0;

    // Short frame dropped, then a good frame.
    build_rand(1'b0);
    tx0 = tx_cnt;
    send_frame(3);
    repeat (30) @(posedge clk);
    #2;
    check("short_err", frame_err, 1'b1);
    check("short_noout", tx_cnt, 64'(tx0));
    build_rand(1'b1);
    send_frame(5);
    wait_done();

    // Reset while idle clears the sticky error and the frame count.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("idle_rst_err", frame_err, 1'b0);
    check("idle_rst_done", frames_done, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    fdone_exp = 0;

    // Long frame dropped, then a good frame.
    build_rand(1'b0);
    frame_w[5] = $urandom;
    tx0 = tx_cnt;
    send_frame(6);
    repeat (30) @(posedge clk);
    #2;
    check("long_err", frame_err, 1'b1);
    check("long_noout", tx_cnt, 64'(tx0));
    build_rand(1'b1);
    send_frame(5);
    wait_done();

    // Reset while output word 2 is presented.
    build_rand(1'b1);
    tx0 = tx_cnt;
    send_frame(5);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #2;
      if (tx_cnt >= tx0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_tmo", ok, 1'b1);
    check("mid_valid", m_axis_tvalid, 1'b1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tlast", m_axis_tlast, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, 32'd0);
    check("mid_rst_done", frames_done, 32'd0);
    check("mid_rst_tready", s_axis_tready, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("mid_rel_tready", s_axis_tready, 1'b1);
    check("mid_rel_tvalid", m_axis_tvalid, 1'b0);
    fdone_exp = 0;

    // Recovery after the abandoned frame.
    build_rand(1'b1);
    send_frame(5);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/redun_out_normalizer.md
# redun_out_normalizer

Sits directly downstream of the squaring unit's outgoing AXI-stream port and feeds the host-bound stream. Each result frame carries t_current, a 16-bit seed tag and the square in redundant form, NUM_WRDS words of WRD_BITS+1 bits each. The block captures one frame, runs a word-serial carry propagation to produce the canonical binary value, and re-emits a packed frame. The host therefore never has to reduce the redundant form itself.

## Interface
Parameters:
- AXI_LEN, 32, stream data width in bits.
- T_LEN, 64, width of the iteration-count field.
- WRD_BITS, redun_mont_pkg::WRD_BITS, canonical digit width.
- NUM_WRDS, redun_mont_pkg::NUM_WRDS, number of redundant words.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word accepted.
- s_axis_tdata  in  AXI_LEN  input word, LSW first.
- s_axis_tlast  in  1  last word of the input frame.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXI_LEN  output word, LSW first.
- m_axis_tkeep  out  AXI_LEN/8  constant all-ones.
- m_axis_tlast  out  1  last word of the output frame.
- frame_err  out  1  sticky flag: a frame had the wrong length.
- frames_done  out  32  count of frames fully sent; wraps at 2^32.

## Operation
- Widths:
  - IN_BITS = T_LEN+16+NUM_WRDS*(WRD_BITS+1).
  - IN_COUNT = ceil(IN_BITS/AXI_LEN).
  - OUT_BITS = T_LEN+16+NUM_WRDS*WRD_BITS+2.
  - OUT_COUNT = ceil(OUT_BITS/AXI_LEN).
- Input frame layout: t_current at bits [T_LEN-1:0], then the seed tag (16 bits), then the redundant words, word i at offset T_LEN+16+i*(WRD_BITS+1). Padding bits are ignored.
- Output frame layout: t_current, then the seed tag, then canonical digits d_0..d_{NUM_WRDS-1}, then a 2-bit final carry. The remainder is zero-padded.
- The two header fields pass through unmodified.
- States and transitions:
  - RECV: s_axis_tready=1. Each accepted word shifts into the input register; a word counter saturates at IN_COUNT+1. On accepted tlast: if the count, including this word, equals IN_COUNT, go to NORM. Otherwise set frame_err, clear the counter, stay in RECV and drop the frame.
  - NORM: one word per cycle, i = 0..NUM_WRDS-1. Compute sum = w_i + carry, a (WRD_BITS+2)-bit addition with carry starting at 0. Then d_i = sum[WRD_BITS-1:0] and carry = sum[WRD_BITS+1:WRD_BITS]; carry never exceeds 2. After word NUM_WRDS-1, load the output shift register and go to SEND.
  - SEND: m_axis_tvalid=1. Data, tlast and valid stay stable until accepted. Each accepted word shifts the register by AXI_LEN. m_axis_tlast=1 when the word index equals OUT_COUNT-1. When the last word is accepted, increment frames_done and go to RECV.
- s_axis_tready=0 outside RECV. The upstream block holds its data in that case.
- Reset (asynchronous, any state, including mid-SEND):
  - state goes to RECV; all counters reset to 0.
  - s_axis_tready=0 while reset_n is low, 1 after release.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - frame_err=0, frames_done=0.
  - A partially sent frame is abandoned with no tlast.

## Timing
- Latency: tlast accepted on edge k → state NORM for edges k+1..k+NUM_WRDS → m_axis_tvalid high from the cycle after edge k+NUM_WRDS. The first output word appears NUM_WRDS+1 cycles after tlast.
- Throughput, no backpressure: IN_COUNT+NUM_WRDS+OUT_COUNT cycles per frame.
- No combinational path from m_axis_tready or s_axis_tvalid to any output other than through registered state.
- tvalid and tready asserted in the same cycle count as exactly one transfer on each side.

## Structure
- Add to redun_mont_pkg: the NORM_IN_COUNT and NORM_OUT_COUNT constants and a state enum, norm_state_t {RECV, NORM, SEND}.
- Sub-module redun_carry_step: a registered single-word carry stage. Inputs w (WRD_BITS+1), carry_in (2) and enable. Outputs d (WRD_BITS) and carry_out (2). The top level sequences it and owns the shift registers and counters.

## Test plan
- NUM_WRDS=4, WRD_BITS=16, T_LEN=64, AXI_LEN=32, so IN_COUNT=5 and OUT_COUNT=5 in every scenario below.
- All-max words: t=5, seed 0xABCD, all w_i=0x1FFFF → digits {0xFFFF, 0x0000, 0x0001, 0x0001}, carry=2, header echoed, m_axis_tlast on word 4, frames_done=1.
- Already canonical input: w_i={0x1234, 0x5678, 0x9ABC, 0xDEF0} → identical digits, carry=0, first m_axis_tvalid exactly 5 cycles after tlast.
- Backpressure: m_axis_tready toggled 1/0 every cycle → every word held stable while stalled, 5 transfers total, s_axis_tready=0 throughout SEND.
- Wrong lengths:
  - Short frame, tlast on word 3 → frame_err=1, no output. A following good frame is processed normally.
  - Long frame of 6 words → same result.
- Reset mid-operation: reset_n pulsed low during SEND word 2 → m_axis_tvalid=0 immediately, frames_done=0, s_axis_tready=1 on the first cycle after release.
